// File: rtl/ili9341_spi_responder_pkg.sv
// Shared types for the ILI9341 SPI responder: command codes, pixel type,
// command-state encoding and the window range check.
package ili9341_spi_responder_pkg;

  typedef enum logic [7:0] {
    CMD_NOP     = 8'h00,
    CMD_SWRESET = 8'h01,
    CMD_CASET   = 8'h2A,
    CMD_PASET   = 8'h2B,
    CMD_RAMWR   = 8'h2C
  } cmd_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CASET    = 3'd1,
    S_PASET    = 3'd2,
    S_RAMWR_HI = 3'd3,
    S_RAMWR_LO = 3'd4
  } state_e;

  function automatic logic window_ok(input logic [15:0] s, input logic [15:0] e,
                                     input logic [15:0] dim);
    return (s <= e) && (e < dim);
  endfunction

endpackage

// File: rtl/ili9341_spi_responder_if.sv
// SPI input bundle plus VRAM write port and status outputs of the responder.
interface ili9341_spi_responder_if #(
  parameter int ADDR_W = 17
);
  import ili9341_spi_responder_pkg::*;

  logic              spi_csb;
  logic              spi_clk;
  logic              spi_mosi;
  logic              data_commandb;
  logic              spi_miso;
  logic              vram_wr_ena;
  logic [ADDR_W-1:0] vram_wr_addr;
  rgb565_t           vram_wr_data;
  logic              cmd_valid;
  logic [7:0]        cmd;
  logic              frame_done;
  logic              window_error;

  modport master (
    output spi_csb, spi_clk, spi_mosi, data_commandb,
    input  spi_miso, vram_wr_ena, vram_wr_addr, vram_wr_data,
    input  cmd_valid, cmd, frame_done, window_error
  );

  modport slave (
    input  spi_csb, spi_clk, spi_mosi, data_commandb,
    output spi_miso, vram_wr_ena, vram_wr_addr, vram_wr_data,
    output cmd_valid, cmd, frame_done, window_error
  );

endinterface

// File: rtl/ili9341_spi_responder_spi_byte_receiver.sv
// Synchronizes the asynchronous SPI pins into clk and assembles MSB-first bytes;
// byte_done pulses one cycle after the 8th sclk rising edge is seen.
module ili9341_spi_responder_spi_byte_receiver (
  input  logic       clk,
  input  logic       rst,
  input  logic       csb,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       dc_in,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       dc
);

  // Bit order in the synchronizer vectors: {dc, mosi, sclk, csb}; csb idles high.
  localparam logic [3:0] SYNC_RST = 4'b0001;

  logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic [7:0] byte_sr_q, byte_sr_d, rx_byte_q, rx_byte_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_done_q, byte_done_d, dc_q, dc_d;
  logic       rise_s;

  // Next-state for synchronizers, edge detect, shifter and bit counter.
  always_comb begin
    sync1_d     = {dc_in, mosi, sclk, csb};
    sync2_d     = sync1_q;
    sclk_prev_d = sync2_q[1];
    rise_s      = sync2_q[1] & ~sclk_prev_q & ~sync2_q[0];
    byte_sr_d   = byte_sr_q;
    bit_cnt_d   = bit_cnt_q;
    rx_byte_d   = rx_byte_q;
    dc_d        = dc_q;
    byte_done_d = 1'b0;
    if (sync2_q[0]) begin
      bit_cnt_d = 3'd0;
    end else if (rise_s) begin
      byte_sr_d = {byte_sr_q[6:0], sync2_q[2]};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_done_d = 1'b1;
        rx_byte_d   = {byte_sr_q[6:0], sync2_q[2]};
        dc_d        = sync2_q[3];
      end else begin
        byte_done_d = 1'b0;
      end
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= SYNC_RST;
      sync2_q     <= SYNC_RST;
      sclk_prev_q <= 1'b0;
      byte_sr_q   <= 8'h00;
      bit_cnt_q   <= 3'd0;
      rx_byte_q   <= 8'h00;
      byte_done_q <= 1'b0;
      dc_q        <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sclk_prev_q <= sclk_prev_d;
      byte_sr_q   <= byte_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_byte_q   <= rx_byte_d;
      byte_done_q <= byte_done_d;
      dc_q        <= dc_d;
    end
  end

  assign rx_byte   = rx_byte_q;
  assign byte_done = byte_done_q;
  assign dc        = dc_q;

endmodule

// File: rtl/ili9341_spi_responder.sv
// ILI9341 display-side SPI write decoder: command FSM, address window,
// write cursor and registered VRAM write port.
module ili9341_spi_responder
  import ili9341_spi_responder_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = 240,
  parameter int DISPLAY_HEIGHT = 320,
  parameter int VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT
) (
  input  logic                    clk,
  input  logic                    rst,
  ili9341_spi_responder_if.slave  bus
);

  localparam int          ADDR_W = $clog2(VRAM_L);
  localparam logic [15:0] W16    = 16'(DISPLAY_WIDTH);
  localparam logic [15:0] H16    = 16'(DISPLAY_HEIGHT);

  logic [7:0] rx_byte;
  logic       byte_done, dc;

  ili9341_spi_responder_spi_byte_receiver u_rx (
    .clk       (clk),
    .rst       (rst),
    .csb       (bus.spi_csb),
    .sclk      (bus.spi_clk),
    .mosi      (bus.spi_mosi),
    .dc_in     (bus.data_commandb),
    .rx_byte   (rx_byte),
    .byte_done (byte_done),
    .dc        (dc)
  );

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [23:0]       tmp_q, tmp_d;
  logic [15:0]       xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [15:0]       cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic              x_ok_q, x_ok_d, y_ok_q, y_ok_d;
  logic [7:0]        hi_q, hi_d, cmd_q, cmd_d;
  logic              wr_ena_q, wr_ena_d, cmd_valid_q, cmd_valid_d;
  logic              frame_done_q, frame_done_d, win_err_q, win_err_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  rgb565_t           wr_data_q, wr_data_d;
  logic [15:0]       par_s, par_e;

  // Command decode, window parameter capture and pixel write generation.
  always_comb begin
    state_d = state_q;  idx_d = idx_q;  tmp_d = tmp_q;
    xs_d = xs_q;  xe_d = xe_q;  ys_d = ys_q;  ye_d = ye_q;
    x_ok_d = x_ok_q;  y_ok_d = y_ok_q;  cur_x_d = cur_x_q;  cur_y_d = cur_y_q;
    hi_d = hi_q;  cmd_d = cmd_q;  win_err_d = win_err_q;
    wr_addr_d = wr_addr_q;  wr_data_d = wr_data_q;
    wr_ena_d = 1'b0;  cmd_valid_d = 1'b0;  frame_done_d = 1'b0;
    par_s = tmp_q[23:8];
    par_e = {tmp_q[7:0], rx_byte};
    if (byte_done && !dc) begin
      cmd_d       = rx_byte;
      cmd_valid_d = 1'b1;
      idx_d       = 3'd0;
      case (cmd_e'(rx_byte))
        CMD_CASET: state_d = S_CASET;
        CMD_PASET: state_d = S_PASET;
        CMD_RAMWR: begin
          state_d = S_RAMWR_HI;
          cur_x_d = xs_q;
          cur_y_d = ys_q;
        end
        CMD_SWRESET: begin
          state_d = S_IDLE;
          xs_d = 16'd0;  xe_d = W16 - 16'd1;  ys_d = 16'd0;  ye_d = H16 - 16'd1;
          x_ok_d = 1'b1;  y_ok_d = 1'b1;  win_err_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (byte_done) begin
      case (state_q)
        S_CASET, S_PASET: begin
          if (idx_q < 3'd3) begin
            tmp_d = {tmp_q[15:0], rx_byte};
            idx_d = idx_q + 3'd1;
          end else if (idx_q == 3'd3) begin
            idx_d = 3'd4;
            // A rejected window keeps its old bounds but blocks writes until fixed.
            if (state_q == S_CASET) begin
              if (window_ok(par_s, par_e, W16)) begin
                xs_d = par_s;  xe_d = par_e;  x_ok_d = 1'b1;
              end else begin
                x_ok_d = 1'b0;  win_err_d = 1'b1;
              end
            end else begin
              if (window_ok(par_s, par_e, H16)) begin
                ys_d = par_s;  ye_d = par_e;  y_ok_d = 1'b1;
              end else begin
                y_ok_d = 1'b0;  win_err_d = 1'b1;
              end
            end
          end else begin
            idx_d = idx_q;
          end
        end
        S_RAMWR_HI: begin
          hi_d    = rx_byte;
          state_d = S_RAMWR_LO;
        end
        S_RAMWR_LO: begin
          state_d = S_RAMWR_HI;
          if (x_ok_q && y_ok_q) begin
            wr_ena_d  = 1'b1;
            wr_addr_d = ADDR_W'(cur_y_q) * ADDR_W'(DISPLAY_WIDTH) + ADDR_W'(cur_x_q);
            wr_data_d = rgb565_t'({hi_q, rx_byte});
            if (cur_x_q < xe_q) begin
              cur_x_d = cur_x_q + 16'd1;
            end else begin
              cur_x_d = xs_q;
              if (cur_y_q < ye_q) begin
                cur_y_d = cur_y_q + 16'd1;
              end else begin
                cur_y_d      = ys_q;
                frame_done_d = 1'b1;
              end
            end
          end else begin
            wr_ena_d = 1'b0;
          end
        end
        default: state_d = state_q;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // All decoder state and outputs, synchronous reset to the full-screen window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;  idx_q <= 3'd0;  tmp_q <= 24'd0;
      xs_q <= 16'd0;  xe_q <= W16 - 16'd1;  ys_q <= 16'd0;  ye_q <= H16 - 16'd1;
      x_ok_q <= 1'b1;  y_ok_q <= 1'b1;  cur_x_q <= 16'd0;  cur_y_q <= 16'd0;
      hi_q <= 8'h00;  cmd_q <= 8'h00;  win_err_q <= 1'b0;
      wr_ena_q <= 1'b0;  wr_addr_q <= '0;  wr_data_q <= '0;
      cmd_valid_q <= 1'b0;  frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;  idx_q <= idx_d;  tmp_q <= tmp_d;
      xs_q <= xs_d;  xe_q <= xe_d;  ys_q <= ys_d;  ye_q <= ye_d;
      x_ok_q <= x_ok_d;  y_ok_q <= y_ok_d;  cur_x_q <= cur_x_d;  cur_y_q <= cur_y_d;
      hi_q <= hi_d;  cmd_q <= cmd_d;  win_err_q <= win_err_d;
      wr_ena_q <= wr_ena_d;  wr_addr_q <= wr_addr_d;  wr_data_q <= wr_data_d;
      cmd_valid_q <= cmd_valid_d;  frame_done_q <= frame_done_d;
    end
  end

  assign bus.spi_miso     = 1'b0;
  assign bus.vram_wr_ena  = wr_ena_q;
  assign bus.vram_wr_addr = wr_addr_q;
  assign bus.vram_wr_data = wr_data_q;
  assign bus.cmd_valid    = cmd_valid_q;
  assign bus.cmd          = cmd_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.window_error = win_err_q;

endmodule
